// File: rtl/alarm_entry_if.sv
// Key/tick inputs and alarm-entry outputs of alarm_entry, grouped as one bundle.
// Signal prefixes are from the alarm_entry (slave) point of view.
interface alarm_entry_if;
  logic       i_one_second;
  logic       i_key_valid;
  logic [3:0] i_key_digit;
  logic       i_key_set_alarm;
  logic       i_key_enter;
  logic       i_key_cancel;

  logic [3:0] o_new_alarm_ms_hr;
  logic [3:0] o_new_alarm_ls_hr;
  logic [3:0] o_new_alarm_ms_min;
  logic [3:0] o_new_alarm_ls_min;
  logic       o_load_new_alarm;
  logic       o_entry_active;
  logic [2:0] o_digit_count;
  logic       o_entry_error;
  logic       o_entry_timeout;

  modport master (
    output i_one_second, i_key_valid, i_key_digit, i_key_set_alarm, i_key_enter, i_key_cancel,
    input  o_new_alarm_ms_hr, o_new_alarm_ls_hr, o_new_alarm_ms_min, o_new_alarm_ls_min,
    input  o_load_new_alarm, o_entry_active, o_digit_count, o_entry_error, o_entry_timeout
  );

  modport slave (
    input  i_one_second, i_key_valid, i_key_digit, i_key_set_alarm, i_key_enter, i_key_cancel,
    output o_new_alarm_ms_hr, o_new_alarm_ls_hr, o_new_alarm_ms_min, o_new_alarm_ls_min,
    output o_load_new_alarm, o_entry_active, o_digit_count, o_entry_error, o_entry_timeout
  );
endinterface

// File: rtl/alarm_entry.sv
// Alarm time entry: collects four BCD digits as HH:MM, validates on enter and
// strobes load/error/timeout. Inactivity for TIMEOUT_SEC ticks aborts entry.
module alarm_entry #(
  parameter int TIMEOUT_SEC = 10
) (
  input  logic         clock,
  input  logic         reset,
  alarm_entry_if.slave bus
);

  localparam int unsigned TW = (TIMEOUT_SEC < 2) ? 1 : $clog2(TIMEOUT_SEC + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_ms_hr, r_ls_hr, r_ms_min, r_ls_min;
  logic [3:0]  w_ms_hr_nxt, w_ls_hr_nxt, w_ms_min_nxt, w_ls_min_nxt;
  logic [2:0]  r_digit_count, w_digit_count_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt, w_timer_inc;
  logic        r_load, r_error, r_timeout;
  logic        w_error_nxt, w_timeout_nxt;
  logic        w_digit_ok, w_time_ok;

  assign w_digit_ok  = bus.i_key_valid && (bus.i_key_digit <= 4'd9);
  assign w_timer_inc = r_timer + 1'b1;

  // HH must be 00..23 and MM 00..59.
  assign w_time_ok = (r_ms_hr <= 4'd2) && (r_ls_hr <= 4'd9) &&
                     !((r_ms_hr == 4'd2) && (r_ls_hr > 4'd3)) &&
                     (r_ms_min <= 4'd5) && (r_ls_min <= 4'd9);

  always_comb begin
    w_state_nxt       = r_state;
    w_ms_hr_nxt       = r_ms_hr;
    w_ls_hr_nxt       = r_ls_hr;
    w_ms_min_nxt      = r_ms_min;
    w_ls_min_nxt      = r_ls_min;
    w_digit_count_nxt = r_digit_count;
    w_timer_nxt       = r_timer;
    w_error_nxt       = 1'b0;
    w_timeout_nxt     = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.i_key_set_alarm) begin
          w_state_nxt       = ST_ENTRY;
          w_ms_hr_nxt       = '0;
          w_ls_hr_nxt       = '0;
          w_ms_min_nxt      = '0;
          w_ls_min_nxt      = '0;
          w_digit_count_nxt = '0;
          w_timer_nxt       = '0;
        end
      end

      ST_ENTRY: begin
        // One event per cycle, highest priority first; an out-of-range digit
        // is not an event, so a coincident tick still counts.
        if (bus.i_key_cancel) begin
          w_state_nxt = ST_IDLE;
        end else if (bus.i_key_set_alarm) begin
          w_ms_hr_nxt       = '0;
          w_ls_hr_nxt       = '0;
          w_ms_min_nxt      = '0;
          w_ls_min_nxt      = '0;
          w_digit_count_nxt = '0;
          w_timer_nxt       = '0;
        end else if (bus.i_key_enter) begin
          if ((r_digit_count == 3'd4) && w_time_ok) begin
            w_state_nxt = ST_LOAD;
          end else begin
            w_state_nxt = ST_IDLE;
            w_error_nxt = 1'b1;
          end
        end else if (w_digit_ok) begin
          w_ms_hr_nxt       = r_ls_hr;
          w_ls_hr_nxt       = r_ms_min;
          w_ms_min_nxt      = r_ls_min;
          w_ls_min_nxt      = bus.i_key_digit;
          w_digit_count_nxt = (r_digit_count == 3'd4) ? r_digit_count : r_digit_count + 3'd1;
          w_timer_nxt       = '0;
        end else if (bus.i_one_second) begin
          if (w_timer_inc == TW'(TIMEOUT_SEC)) begin
            w_state_nxt   = ST_IDLE;
            w_timeout_nxt = 1'b1;
          end else begin
            w_timer_nxt = w_timer_inc;
          end
        end
      end

      ST_LOAD: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_ms_hr       <= '0;
      r_ls_hr       <= '0;
      r_ms_min      <= '0;
      r_ls_min      <= '0;
      r_digit_count <= '0;
      r_timer       <= '0;
      r_load        <= 1'b0;
      r_error       <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ms_hr       <= w_ms_hr_nxt;
      r_ls_hr       <= w_ls_hr_nxt;
      r_ms_min      <= w_ms_min_nxt;
      r_ls_min      <= w_ls_min_nxt;
      r_digit_count <= w_digit_count_nxt;
      r_timer       <= w_timer_nxt;
      r_load        <= (w_state_nxt == ST_LOAD);
      r_error       <= w_error_nxt;
      r_timeout     <= w_timeout_nxt;
    end
  end

  assign bus.o_new_alarm_ms_hr  = r_ms_hr;
  assign bus.o_new_alarm_ls_hr  = r_ls_hr;
  assign bus.o_new_alarm_ms_min = r_ms_min;
  assign bus.o_new_alarm_ls_min = r_ls_min;
  assign bus.o_load_new_alarm   = r_load;
  assign bus.o_entry_active     = (r_state == ST_ENTRY);
  assign bus.o_digit_count      = r_digit_count;
  assign bus.o_entry_error      = r_error;
  assign bus.o_entry_timeout    = r_timeout;

endmodule

// File: tb/tb_alarm_entry.sv
// Testbench for alarm_entry: directed scenarios plus randomized key traffic
// checked cycle by cycle against a digit-list / HH:MM reference model.
module tb_alarm_entry;

  localparam int TOUT = 10;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  alarm_entry_if bus ();

  alarm_entry #(.TIMEOUT_SEC(TOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: mode 0 idle, 1 collecting digits, 2 loading.
  int m_mode;
  int m_d[4];
  int m_cnt;
  int m_ticks;
  bit m_load, m_err, m_to;

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_ticks = 0;
    m_load = 0; m_err = 0; m_to = 0;
    for (int i = 0; i < 4; i++) m_d[i] = 0;
  endtask

  task automatic model_clear();
    m_cnt = 0; m_ticks = 0;
    for (int i = 0; i < 4; i++) m_d[i] = 0;
  endtask

  task automatic model_step(input bit set, enter, cancel, valid, input int digit, input bit tick);
    int hh, mm;
    m_load = 0; m_err = 0; m_to = 0;
    hh = m_d[0] * 10 + m_d[1];
    mm = m_d[2] * 10 + m_d[3];
    if (m_mode == 2) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (set) begin m_mode = 1; model_clear(); end
    end else begin
      if (cancel) m_mode = 0;
      else if (set) model_clear();
      else if (enter) begin
        if (m_cnt == 4 && hh < 24 && mm < 60) begin m_mode = 2; m_load = 1; end
        else begin m_mode = 0; m_err = 1; end
      end else if (valid && digit <= 9) begin
        m_d[0] = m_d[1]; m_d[1] = m_d[2]; m_d[2] = m_d[3]; m_d[3] = digit;
        if (m_cnt < 4) m_cnt++;
        m_ticks = 0;
      end else if (tick) begin
        m_ticks++;
        if (m_ticks == TOUT) begin m_mode = 0; m_to = 1; end
      end
    end
  endtask

  function automatic logic [22:0] obs();
    return {bus.o_new_alarm_ms_hr, bus.o_new_alarm_ls_hr, bus.o_new_alarm_ms_min,
            bus.o_new_alarm_ls_min, bus.o_load_new_alarm, bus.o_entry_active,
            bus.o_digit_count, bus.o_entry_error, bus.o_entry_timeout};
  endfunction

  function automatic logic [22:0] model_vec();
    return {4'(m_d[0]), 4'(m_d[1]), 4'(m_d[2]), 4'(m_d[3]), m_load, m_mode == 1,
            3'(m_cnt), m_err, m_to};
  endfunction

  // Packs expected outputs: buffer, load, active, count, error, timeout.
  function automatic logic [22:0] ev(input logic [15:0] b, input logic ld, act,
                                     input logic [2:0] cnt, input logic er, to);
    return {b, ld, act, cnt, er, to};
  endfunction

  task automatic clear_inputs();
    bus.i_one_second = 0; bus.i_key_valid = 0; bus.i_key_digit = '0;
    bus.i_key_set_alarm = 0; bus.i_key_enter = 0; bus.i_key_cancel = 0;
  endtask

  // Drives one cycle of inputs from a negedge, returns at the next negedge.
  task automatic step(input bit set, enter, cancel, valid, input logic [3:0] digit, input bit tick);
    bus.i_key_set_alarm = set; bus.i_key_enter = enter; bus.i_key_cancel = cancel;
    bus.i_key_valid = valid; bus.i_key_digit = digit; bus.i_one_second = tick;
    @(posedge clock);
    model_step(set, enter, cancel, valid, int'(digit), tick);
    @(negedge clock);
    clear_inputs();
  endtask

  task automatic key(input logic [3:0] d);  step(0, 0, 0, 1, d, 0); endtask
  task automatic idle();                    step(0, 0, 0, 0, 4'd0, 0); endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [22:0] e;
    apply_reset();
    e = '0;
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL reset_state got=%h exp=%h", obs(), e); end
    step(0, 1, 0, 0, 4'd0, 0);
    key(4'd5);
    step(0, 0, 1, 0, 4'd0, 1);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL idle_ignores got=%h exp=%h", obs(), e); end
  endtask

  task automatic test_load_valid();
    logic [22:0] e;
    step(1, 0, 0, 0, 4'd0, 0);
    key(4'd0); key(4'd7); key(4'd3); key(4'd0);
    step(0, 1, 0, 0, 4'd0, 0);
    e = ev(16'h0730, 1, 0, 3'd4, 0, 0);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL load_pulse got=%h exp=%h", obs(), e); end
    idle();
    e = ev(16'h0730, 0, 0, 3'd4, 0, 0);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL load_after got=%h exp=%h", obs(), e); end
  endtask

  task automatic test_invalid_time();
    logic [22:0] e;
    logic [15:0] seqs [2];
    seqs[0] = 16'h2400;
    seqs[1] = 16'h1260;
    for (int s = 0; s < 2; s++) begin
      step(1, 0, 0, 0, 4'd0, 0);
      for (int k = 0; k < 4; k++) key(seqs[s][15 - 4*k -: 4]);
      step(0, 1, 0, 0, 4'd0, 0);
      e = ev(seqs[s], 0, 0, 3'd4, 1, 0);
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL invalid_err got=%h exp=%h", obs(), e); end
      idle();
      e = ev(seqs[s], 0, 0, 3'd4, 0, 0);
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL invalid_after got=%h exp=%h", obs(), e); end
    end
  endtask

  task automatic test_short_entry();
    logic [22:0] e;
    step(1, 0, 0, 0, 4'd0, 0);
    key(4'd1); key(4'd2);
    step(0, 1, 0, 0, 4'd0, 0);
    e = ev(16'h0012, 0, 0, 3'd2, 1, 0);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL short_err got=%h exp=%h", obs(), e); end
  endtask

  task automatic test_shift_saturate();
    logic [22:0] e;
    step(1, 0, 0, 0, 4'd0, 0);
    for (int k = 1; k <= 5; k++) key(4'(k));
    e = ev(16'h2345, 0, 1, 3'd4, 0, 0);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL saturate got=%h exp=%h", obs(), e); end
    key(4'hA);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL bad_digit got=%h exp=%h", obs(), e); end
    step(0, 1, 0, 0, 4'd0, 0);
    e = ev(16'h2345, 1, 0, 3'd4, 0, 0);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL sat_load got=%h exp=%h", obs(), e); end
    idle();
  endtask

  task automatic test_timeout();
    logic [22:0] e;
    step(1, 0, 0, 0, 4'd0, 0);
    for (int k = 0; k < TOUT - 1; k++) step(0, 0, 0, 0, 4'd0, 1);
    step(0, 0, 0, 1, 4'd1, 1);
    for (int k = 0; k < TOUT - 1; k++) step(0, 0, 0, 0, 4'd0, 1);
    e = ev(16'h0001, 0, 1, 3'd1, 0, 0);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL pre_timeout got=%h exp=%h", obs(), e); end
    step(0, 0, 0, 0, 4'd0, 1);
    e = ev(16'h0001, 0, 0, 3'd1, 0, 1);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL timeout got=%h exp=%h", obs(), e); end
    idle();
    e = ev(16'h0001, 0, 0, 3'd1, 0, 0);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL timeout_after got=%h exp=%h", obs(), e); end
  endtask

  task automatic test_cancel_and_reset();
    logic [22:0] e;
    step(1, 0, 0, 0, 4'd0, 0);
    key(4'd1);
    step(0, 1, 1, 0, 4'd0, 0);
    e = ev(16'h0001, 0, 0, 3'd1, 0, 0);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL cancel got=%h exp=%h", obs(), e); end
    idle();
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL cancel_after got=%h exp=%h", obs(), e); end
    step(1, 0, 0, 0, 4'd0, 0);
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    #2 reset = 1'b1;
    model_reset();
    #1;
    e = '0;
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL async_reset got=%h exp=%h", obs(), e); end
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) idle();
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL post_reset got=%h exp=%h", obs(), e); end
  endtask

  task automatic test_random();
    int r;
    int bad;
    bad = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        apply_reset();
      end else begin
        r = $urandom_range(0, 99);
        step(r < 4, (r >= 4 && r < 10) || (r == 97), (r >= 10 && r < 13) || (r == 98),
             r >= 40, 4'($urandom_range(0, 11)), $urandom_range(0, 2) == 0);
      end
      checks++;
      if (obs() !== model_vec()) begin
        errors++;
        bad++;
        if (bad <= 10) $display("FAIL random cyc=%0d got=%h exp=%h", n, obs(), model_vec());
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    clear_inputs();
    model_reset();
    @(negedge clock);
    test_reset();
    test_load_valid();
    test_invalid_time();
    test_short_entry();
    test_shift_saturate();
    test_timeout();
    test_cancel_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
